uart_rx_pkt_ctrl: RTL and testbench

Packet sequencer behind the UART byte receiver. It watches the receiver's idle/valid level and parallel byte, and assembles 4-byte command packets (header, address, data, checksum). Checked packets become one-cycle register-write strobes for the downstream register bank. Bad or stalled packets are dropped and reported on an error strobe.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_gap_timer.sv | 30 +++
 rtl/uart_rx_pkt_ctrl.sv | 112 +++++++++++
 tb/tb_uart_rx_pkt_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART packet sequencer: FSM encoding, error codes, defaults.
// No logic; latency n/a.
// Backpressure n/a.
package uart_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_CSUM = 2'd3;

    localparam logic [1:0] ERR_CSUM = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

    localparam logic [7:0]  HEADER_DEF  = 8'h55;
    localparam logic [15:0] TIMEOUT_DEF = 16'd8680;

    // Packet checksum is the 8-bit wrapping sum of address and data.
    function automatic logic [7:0] pkt_csum(input logic [7:0] addr, input logic [7:0] data);
        return addr + data;
    endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer; tc is high while enabled and the count sits at TIMEOUT_CYC.
// Latency: count registered, tc combinational from count.
// Backpressure: none; clr has priority over en.
module uart_gap_timer
    import uart_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [15:0] cnt;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 16'd0;
        end else if (clr) begin
            cnt <= 16'd0;
        end else if (en) begin
            cnt <= cnt + 16'd1;
        end
    end

    assign tc = en && (cnt == TIMEOUT_CYC);

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Assembles header/addr/data/csum packets from UART bytes into write or error strobes; UART_PKT_STAT_EN adds counters.
// Latency: wr_en/err_stb high the cycle after the edge consuming the checksum byte (or the timeout).
// Backpressure: none; bytes are consumed on every rx_valid rising edge.
module uart_rx_pkt_ctrl
    import uart_pkg::*;
#(
    parameter logic [7:0]  HEADER      = HEADER_DEF,
    parameter logic [15:0] TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        err_stb,
    output logic [1:0]  err_code,
    output logic        busy,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
);

    logic       rx_valid_d;
    logic       byte_stb;
    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [7:0] addr_r;
    logic [7:0] data_r;
    logic       tc;
    logic       tmo;
    logic       accept;
    logic       reject;

    assign byte_stb = rx_valid & ~rx_valid_d;
    // A byte arriving on the terminal-count cycle beats the timeout.
    assign tmo      = tc & ~byte_stb;

    uart_gap_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_gap_timer (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .clr     ((state == ST_IDLE) | byte_stb | tmo),
        .en      (state != ST_IDLE),
        .tc      (tc)
    );

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        reject    = 1'b0;
        case (state)
            ST_IDLE: if (byte_stb && (rx_data == HEADER)) state_nxt = ST_ADDR;
            ST_ADDR: if (byte_stb) state_nxt = ST_DATA;
            ST_DATA: if (byte_stb) state_nxt = ST_CSUM;
            default: begin
                if (byte_stb) begin
                    state_nxt = ST_IDLE;
                    accept    = (rx_data == pkt_csum(addr_r, data_r));
                    reject    = (rx_data != pkt_csum(addr_r, data_r));
                end
            end
        endcase
        if (tmo) state_nxt = ST_IDLE;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_d <= 1'b1;
            state      <= ST_IDLE;
            addr_r     <= 8'd0;
            data_r     <= 8'd0;
            wr_en      <= 1'b0;
            wr_addr    <= 8'd0;
            wr_data    <= 8'd0;
            err_stb    <= 1'b0;
            err_code   <= 2'b00;
            busy       <= 1'b0;
        end else begin
            rx_valid_d <= rx_valid;
            state      <= state_nxt;
            busy       <= (state_nxt != ST_IDLE);
            wr_en      <= accept;
            err_stb    <= reject | tmo;
            if (byte_stb && (state == ST_ADDR)) addr_r <= rx_data;
            if (byte_stb && (state == ST_DATA)) data_r <= rx_data;
            if (accept) begin
                wr_addr <= addr_r;
                wr_data <= data_r;
            end
            if (reject) err_code <= ERR_CSUM;
            else if (tmo) err_code <= ERR_TMO;
        end
    end

`ifdef UART_PKT_STAT_EN
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            good_cnt <= 16'd0;
            bad_cnt  <= 16'd0;
        end else begin
            if (wr_en && (good_cnt != 16'hFFFF)) good_cnt <= good_cnt + 16'd1;
            if (err_stb && (bad_cnt != 16'hFFFF)) bad_cnt <= bad_cnt + 16'd1;
        end
    end
`else
    assign good_cnt = 16'd0;
    assign bad_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Directed self-checking bench for uart_rx_pkt_ctrl (default HEADER 55, TIMEOUT_CYC 8680).
module tb_uart_rx_pkt_ctrl;

    localparam int T = 8680;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        err_stb;
    logic [1:0]  err_code;
    logic        busy;
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;

    int checks   = 0;
    int failures = 0;
    int n_wr     = 0;
    int n_err    = 0;
    int n_both   = 0;

    uart_rx_pkt_ctrl dut (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .err_stb  (err_stb),
        .err_code (err_code),
        .busy     (busy),
        .good_cnt (good_cnt),
        .bad_cnt  (bad_cnt)
    );

    always #10 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (rst_n) begin
            if (wr_en) n_wr++;
            if (err_stb) n_err++;
            if (wr_en && err_stb) n_both++;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Returns #1 into the cycle in which byte_stb is high.
    task automatic send(input logic [7:0] b);
        @(posedge sys_clk);
        #1 rx_valid = 1'b0;
        @(posedge sys_clk);
        #1 rx_data = b;
        rx_valid = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rx_valid = 1'b1;
        rx_data = 8'h00;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(4);
        checks++;
        if ({wr_en, err_stb, err_code, busy, wr_addr, wr_data} !== 21'd0) begin
            failures++;
            $display("FAIL reset_outputs got wr_en=%b err_stb=%b code=%b busy=%b addr=%h data=%h, want all 0",
                     wr_en, err_stb, err_code, busy, wr_addr, wr_data);
        end
        checks++;
        if ({good_cnt, bad_cnt} !== 32'd0) begin
            failures++;
            $display("FAIL reset_counters got good=%0d bad=%0d want 0 0", good_cnt, bad_cnt);
        end
        checks++;
        if (n_wr + n_err !== 0) begin
            failures++;
            $display("FAIL reset_no_fake_strobe got %0d strobes want 0", n_wr + n_err);
        end
    endtask

    task automatic test_good_packet;
        send(8'h55); send(8'h12); send(8'h34);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL good_busy got %b want 1", busy);
        end
        send(8'h46);
        checks++;
        if (wr_en !== 1'b0) begin
            failures++;
            $display("FAIL good_wr_early got %b want 0", wr_en);
        end
        wait_cyc(1);
        checks++;
        if ({wr_en, err_stb, wr_addr, wr_data} !== {1'b1, 1'b0, 8'h12, 8'h34}) begin
            failures++;
            $display("FAIL good_write got wr_en=%b err=%b addr=%h data=%h want 1 0 12 34",
                     wr_en, err_stb, wr_addr, wr_data);
        end
        wait_cyc(1);
        checks++;
        if ({wr_en, busy} !== 2'b00) begin
            failures++;
            $display("FAIL good_width got wr_en=%b busy=%b want 0 0", wr_en, busy);
        end
`ifdef UART_PKT_STAT_EN
        checks++;
        if (good_cnt !== 16'd1) begin
            failures++;
            $display("FAIL good_cnt got %0d want 1", good_cnt);
        end
`endif
    endtask

    task automatic test_bad_csum;
        int w0;
        w0 = n_wr;
        send(8'h55); send(8'h12); send(8'h34); send(8'h47);
        wait_cyc(1);
        checks++;
        if ({err_stb, err_code, wr_en} !== {1'b1, 2'b01, 1'b0}) begin
            failures++;
            $display("FAIL csum_err got err=%b code=%b wr_en=%b want 1 01 0", err_stb, err_code, wr_en);
        end
        wait_cyc(1);
        checks++;
        if ({err_stb, wr_addr, wr_data} !== {1'b0, 8'h12, 8'h34} || n_wr !== w0) begin
            failures++;
            $display("FAIL csum_hold got err=%b addr=%h data=%h writes=%0d want 0 12 34 %0d",
                     err_stb, wr_addr, wr_data, n_wr, w0);
        end
    endtask

    task automatic test_skip_and_wrap;
        int e0;
        e0 = n_err;
        send(8'hA0); send(8'hFF);
        wait_cyc(2);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL skip_busy got %b want 0", busy);
        end
        send(8'h55); send(8'hF0); send(8'h20); send(8'h10);
        wait_cyc(1);
        checks++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 8'hF0, 8'h20} || n_err !== e0) begin
            failures++;
            $display("FAIL wrap_write got wr_en=%b addr=%h data=%h errs=%0d want 1 f0 20 %0d",
                     wr_en, wr_addr, wr_data, n_err, e0);
        end
    endtask

    task automatic test_timeout;
        int waited;
        send(8'h55); send(8'h12);
        waited = 0;
        while (waited < 9000 && err_stb !== 1'b1) begin
            wait_cyc(1);
            waited++;
        end
        checks++;
        if (waited !== T + 2) begin
            failures++;
            $display("FAIL tmo_latency got %0d cycles want %0d", waited, T + 2);
        end
        checks++;
        if ({err_code, busy, wr_en} !== {2'b10, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL tmo_state got code=%b busy=%b wr_en=%b want 10 0 0", err_code, busy, wr_en);
        end
        send(8'h55); send(8'h01); send(8'h02); send(8'h03);
        wait_cyc(1);
        checks++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 8'h01, 8'h02}) begin
            failures++;
            $display("FAIL tmo_recover got wr_en=%b addr=%h data=%h want 1 01 02", wr_en, wr_addr, wr_data);
        end
    endtask

    task automatic test_terminal_count;
        int e0;
        e0 = n_err;
        send(8'h55);
        wait_cyc(T - 1);
        send(8'h55);
        wait_cyc(2);
        checks++;
        if ({busy, err_stb} !== 2'b10 || n_err !== e0) begin
            failures++;
            $display("FAIL tc_byte_wins got busy=%b err=%b errs=%0d want 1 0 %0d", busy, err_stb, n_err, e0);
        end
        send(8'h00); send(8'h55);
        wait_cyc(1);
        checks++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 8'h55, 8'h00}) begin
            failures++;
            $display("FAIL tc_accept got wr_en=%b addr=%h data=%h want 1 55 00", wr_en, wr_addr, wr_data);
        end
        // One cycle later than terminal count: the timeout fires first.
        send(8'h55);
        wait_cyc(T);
        send(8'h12);
        checks++;
        if ({err_stb, err_code} !== {1'b1, 2'b10}) begin
            failures++;
            $display("FAIL tc_late got err=%b code=%b want 1 10", err_stb, err_code);
        end
        wait_cyc(2);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL tc_late_busy got %b want 0", busy);
        end
    endtask

    task automatic test_reset_mid_packet;
        int w0;
        int e0;
`ifdef UART_PKT_STAT_EN
        checks++;
        if ({good_cnt, bad_cnt} !== {16'd4, 16'd3}) begin
            failures++;
            $display("FAIL stat_totals got good=%0d bad=%0d want 4 3", good_cnt, bad_cnt);
        end
`endif
        send(8'h55); send(8'h12); send(8'h34);
        wait_cyc(1);
        w0 = n_wr;
        e0 = n_err;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({wr_en, err_stb, err_code, busy, wr_addr, wr_data, good_cnt, bad_cnt} !== 53'd0) begin
            failures++;
            $display("FAIL midrst_outputs got wr_en=%b err=%b code=%b busy=%b addr=%h data=%h good=%0d bad=%0d want all 0",
                     wr_en, err_stb, err_code, busy, wr_addr, wr_data, good_cnt, bad_cnt);
        end
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(5);
        checks++;
        if (n_wr !== w0 || n_err !== e0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_abort got writes=%0d errs=%0d busy=%b want %0d %0d 0", n_wr, n_err, busy, w0, e0);
        end
        send(8'h55); send(8'hAA); send(8'h01); send(8'hAB);
        wait_cyc(1);
        checks++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 8'hAA, 8'h01}) begin
            failures++;
            $display("FAIL midrst_recover got wr_en=%b addr=%h data=%h want 1 aa 01", wr_en, wr_addr, wr_data);
        end
        wait_cyc(1);
`ifdef UART_PKT_STAT_EN
        checks++;
        if ({good_cnt, bad_cnt} !== {16'd1, 16'd0}) begin
            failures++;
            $display("FAIL stat_after_reset got good=%0d bad=%0d want 1 0", good_cnt, bad_cnt);
        end
`else
        checks++;
        if ({good_cnt, bad_cnt} !== 32'd0) begin
            failures++;
            $display("FAIL stat_tied got good=%0d bad=%0d want 0 0", good_cnt, bad_cnt);
        end
`endif
    endtask

    initial begin
        test_reset;
        test_good_packet;
        test_bad_csum;
        test_skip_and_wrap;
        test_timeout;
        test_terminal_count;
        test_reset_mid_packet;
        checks++;
        if (n_both !== 0) begin
            failures++;
            $display("FAIL exclusive_strobes got %0d overlapping cycles want 0", n_both);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
